// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: priority-decoded per-stage stalls, exception
// flush with one-cycle settle, stall watchdog and activity counters.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [31:0] ERET_CODE = 32'h0000000e;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] run_reg, run_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] stall_cycles_reg, stall_cycles_next;
  logic [15:0] flush_count_reg, flush_count_next;

  logic [2:0]  stall_level;
  logic [5:0]  stall_raw;
  logic [5:0]  stall_core;
  logic        flush_core;
  logic [31:0] new_pc_core;
  logic        stalled;

  // Deepest requesting stage sets how many low-order stages are held.
  always_comb begin
    stall_level = 3'd0;
    if (stallreq_mem)     stall_level = 3'd5;
    else if (stallreq_ex) stall_level = 3'd4;
    else if (stallreq_id) stall_level = 3'd3;
    else if (stallreq_if) stall_level = 3'd2;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_stall_mask
      assign stall_raw[gi] = (stall_level > 3'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    flush_core  = 1'b0;
    new_pc_core = 32'd0;
    stall_core  = stall_raw;
    case (state_reg)
      IDLE: begin
        if (excepttype_i != 32'd0) begin
          flush_core  = 1'b1;
          stall_core  = 6'b000000;
          new_pc_core = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
          state_next  = SETTLE;
        end
      end
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset only masks the visible outputs; the registers clear through the async path.
  assign stall  = rst ? stall_core  : 6'b000000;
  assign flush  = rst ? flush_core  : 1'b0;
  assign new_pc = rst ? new_pc_core : 32'd0;

  assign stalled = (stall_core != 6'b000000);

  always_comb begin
    run_next          = 16'd0;
    if (stalled)
      run_next        = (run_reg == 16'hFFFF) ? run_reg : run_reg + 16'd1;
    timeout_next      = timeout_reg | (stalled && (run_next >= TIMEOUT));
    stall_cycles_next = stall_cycles_reg + {31'd0, stalled};
    flush_count_next  = flush_count_reg;
    if (flush_core && (flush_count_reg != 16'hFFFF))
      flush_count_next = flush_count_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      run_reg          <= 16'd0;
      timeout_reg      <= 1'b0;
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      state_reg        <= state_next;
      run_reg          <= run_next;
      timeout_reg      <= timeout_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
    end
  end

  assign stall_timeout = timeout_reg;
  assign stall_cycles  = stall_cycles_reg;
  assign flush_count   = flush_count_reg;

endmodule
